// File: rtl/jtdsp16_rom_cache_if.sv
// Bus bundle between the DSP core / external ROM side and the program-memory
// fetch cache. The cache is the slave; the core and ROM controller drive the
// master side.
interface jtdsp16_rom_cache_if #(
   parameter int DW = 16
);
   logic          cen;       // core clock enable request
   logic          flush;     // invalidate every cache entry
   logic [15:0]   addr;      // program counter
   logic [DW-1:0] dout;      // instruction word for addr
   logic          core_cen;  // gated core clock enable
   logic          stall;     // miss pending
   logic          ext_cs;    // external ROM request
   logic [15:0]   ext_addr;  // external ROM address
   logic [DW-1:0] ext_data;  // external ROM data
   logic          ext_ok;    // external data valid, held until ext_cs drops

   modport slave (
      input  cen, flush, addr, ext_data, ext_ok,
      output dout, core_cen, stall, ext_cs, ext_addr
   );

   modport master (
      output cen, flush, addr, ext_data, ext_ok,
      input  dout, core_cen, stall, ext_cs, ext_addr
   );
endinterface

// File: rtl/jtdsp16_rom_cache.sv
// Direct-mapped instruction cache in front of a variable-latency program ROM.
// Hits are served combinationally; a miss withholds the core clock enable
// while a single-word fill is fetched through the ext_* handshake.
module jtdsp16_rom_cache #(
   parameter int AW = 4,
   parameter int DW = 16
) (
   input  logic                 clk,
   input  logic                 rstn,
   jtdsp16_rom_cache_if.slave   bus
);
   localparam int N  = 1 << AW;
   localparam int TW = 16 - AW;

   typedef enum logic { IDLE = 1'b0, WAIT = 1'b1 } state_t;

   state_t         state_reg, state_next;
   logic           ext_cs_reg, ext_cs_next;
   logic [15:0]    ext_addr_reg, ext_addr_next;
   logic           flush_latch_reg, flush_latch_next;
   logic [N-1:0]   valid_reg, valid_next;

   // Data and tag storage carry no reset; only the valid bits matter after reset
   logic [DW-1:0]  data_mem [N];
   logic [TW-1:0]  tag_mem  [N];

   logic [AW-1:0]  idx;
   logic [TW-1:0]  addr_tag;
   logic [AW-1:0]  fill_idx;
   logic           hit;
   logic           fill_done;
   logic           fill_valid;

   assign idx      = bus.addr[AW-1:0];
   assign addr_tag = bus.addr[15:AW];
   assign fill_idx = ext_addr_reg[AW-1:0];

   // Lookup is combinational so a hit costs no extra cycle
   assign hit = valid_reg[idx] && (tag_mem[idx] == addr_tag);

   assign bus.dout     = hit ? data_mem[idx] : '0;
   assign bus.stall    = !hit || (state_reg != IDLE);
   assign bus.core_cen = bus.cen && !bus.stall;
   assign bus.ext_cs   = ext_cs_reg;
   assign bus.ext_addr = ext_addr_reg;

   // Next-state logic: launch a fill on a miss, retire it when ext_ok arrives
   always_comb begin
      state_next       = state_reg;
      ext_cs_next      = ext_cs_reg;
      ext_addr_next    = ext_addr_reg;
      flush_latch_next = flush_latch_reg;
      fill_done        = 1'b0;
      case (state_reg)
         IDLE: begin
            flush_latch_next = 1'b0;
            if (!hit) begin
               ext_addr_next = bus.addr;
               ext_cs_next   = 1'b1;
               state_next    = WAIT;
            end
         end
         WAIT: begin
            if (bus.ext_ok) begin
               fill_done        = 1'b1;
               ext_cs_next      = 1'b0;
               flush_latch_next = 1'b0;
               state_next       = IDLE;
            end else if (bus.flush) begin
               // Remember the flush so the in-flight word is not marked valid
               flush_latch_next = 1'b1;
            end
         end
         default: begin
            state_next  = IDLE;
            ext_cs_next = 1'b0;
         end
      endcase
   end

   // A fill that overlaps a flush completes its handshake but stays invalid
   assign fill_valid = fill_done && !bus.flush && !flush_latch_reg;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_valid
         assign valid_next[gi] = bus.flush ? 1'b0 :
                                 (fill_valid && fill_idx == AW'(gi)) ? 1'b1 :
                                 valid_reg[gi];
      end
   endgenerate

   // Control registers; reset aborts any pending request immediately
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg       <= IDLE;
         ext_cs_reg      <= 1'b0;
         ext_addr_reg    <= 16'h0000;
         flush_latch_reg <= 1'b0;
         valid_reg       <= '0;
      end else begin
         state_reg       <= state_next;
         ext_cs_reg      <= ext_cs_next;
         ext_addr_reg    <= ext_addr_next;
         flush_latch_reg <= flush_latch_next;
         valid_reg       <= valid_next;
      end
   end

   // Fill write into the data and tag arrays (direct-mapped overwrite)
   always_ff @(posedge clk) begin
      if (fill_done) begin
         data_mem[fill_idx] <= bus.ext_data;
         tag_mem[fill_idx]  <= ext_addr_reg[15:AW];
      end
   end
endmodule

// File: tb/tb_jtdsp16_rom_cache.sv
// Self-checking bench for jtdsp16_rom_cache: a variable-latency ROM responder,
// a request monitor and a direct-mapped cache model predicting hits, stall
// lengths and returned words.
module tb_jtdsp16_rom_cache;
   logic clk;
   logic rstn;
   int   errors = 0;
   int   checks = 0;
   int   req_cnt = 0;
   int   lat = 1;

   jtdsp16_rom_cache_if #(.DW(16)) bus ();

   jtdsp16_rom_cache #(.AW(4), .DW(16)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cache model: which address currently occupies each of the 16 lines
   logic        m_valid [16];
   logic [11:0] m_tag   [16];

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      logic [15:0] w;
      w = (a * 16'h9E37) ^ 16'h5A5A;
      if (a == 16'h0000) w = 16'h1234;
      return w;
   endfunction

   function automatic logic model_hit(input logic [15:0] a);
      return m_valid[a[3:0]] && (m_tag[a[3:0]] == a[15:4]);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
   endtask

   task automatic model_fill(input logic [15:0] a);
      m_valid[a[3:0]] = 1'b1;
      m_tag[a[3:0]]   = a[15:4];
   endtask

   // ROM responder: ext_ok rises after 'lat' cycles of ext_cs, held until ext_cs drops
   initial begin
      int cnt;
      cnt = 0;
      bus.ext_ok   = 1'b0;
      bus.ext_data = '0;
      forever begin
         @(posedge clk);
         #1;
         if (bus.ext_cs) begin
            cnt++;
            if (cnt >= lat) begin
               bus.ext_ok   = 1'b1;
               bus.ext_data = mem_word(bus.ext_addr);
            end
         end else begin
            cnt = 0;
            bus.ext_ok   = 1'b0;
            bus.ext_data = '0;
         end
      end
   end

   // Request monitor: counts requests, checks ext_addr stability while ext_cs is held
   initial begin
      logic        cs_prev;
      logic [15:0] addr_prev;
      cs_prev   = 1'b0;
      addr_prev = '0;
      forever begin
         @(negedge clk);
         if (bus.ext_cs && !cs_prev) req_cnt++;
         if (bus.ext_cs && cs_prev) begin
            checks++;
            if (bus.ext_addr !== addr_prev) begin
               errors++;
               $display("FAIL ext_addr_stable: got %h required %h", bus.ext_addr, addr_prev);
            end
         end
         cs_prev   = bus.ext_cs;
         addr_prev = bus.ext_addr;
      end
   end

   // One fetch, entered and left at posedge+1; returns number of stall cycles
   task automatic fetch(input logic [15:0] a, input int lat_i, output int stalls);
      logic exp_hit;
      int   req0;
      int   exp_stalls;
      exp_hit = model_hit(a);
      req0    = req_cnt;
      bus.addr = a;
      bus.cen  = 1'b1;
      lat      = lat_i;
      @(negedge clk);
      checks++;
      if (bus.stall !== !exp_hit) begin
         errors++;
         $display("FAIL hit_predict addr=%h: stall %b required %b", a, bus.stall, !exp_hit);
      end
      stalls = 0;
      while (bus.stall === 1'b1 && stalls < 200) begin
         stalls++;
         @(negedge clk);
      end
      exp_stalls = exp_hit ? 0 : lat_i + 1;
      checks++;
      if (stalls != exp_stalls) begin
         errors++;
         $display("FAIL miss_penalty addr=%h: %0d stall cycles required %0d", a, stalls, exp_stalls);
      end
      checks++;
      if (bus.dout !== mem_word(a)) begin
         errors++;
         $display("FAIL fetch_data addr=%h: got %h required %h", a, bus.dout, mem_word(a));
      end
      checks++;
      if (bus.core_cen !== 1'b1) begin
         errors++;
         $display("FAIL fetch_core_cen addr=%h: got %b required 1", a, bus.core_cen);
      end
      checks++;
      if (req_cnt - req0 != (exp_hit ? 0 : 1)) begin
         errors++;
         $display("FAIL fetch_requests addr=%h: %0d requests required %0d", a, req_cnt - req0, exp_hit ? 0 : 1);
      end
      $display("fetch addr=%h hit=%b stalls=%0d dout=%h", a, exp_hit, stalls, bus.dout);
      model_fill(a);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      int stalls;
      rstn      = 1'b0;
      bus.cen   = 1'b1;
      bus.flush = 1'b0;
      bus.addr  = 16'h0000;
      lat       = 3;
      model_clear();
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.ext_cs !== 1'b0 || bus.stall !== 1'b1 || bus.core_cen !== 1'b0 || bus.dout !== 16'h0) begin
         errors++;
         $display("FAIL reset_outputs: cs=%b stall=%b core_cen=%b dout=%h required 0 1 0 0000",
                  bus.ext_cs, bus.stall, bus.core_cen, bus.dout);
      end
      @(posedge clk);
      #1;
      rstn = 1'b1;
      // Cycle 0 begins here
      stalls = 0;
      @(negedge clk);
      while (bus.stall === 1'b1 && stalls < 50) begin
         stalls++;
         if (stalls == 1) begin
            checks++;
            if (bus.ext_cs !== 1'b0) begin
               errors++;
               $display("FAIL cold_cs_cycle0: got %b required 0", bus.ext_cs);
            end
         end
         if (stalls == 2) begin
            checks++;
            if (bus.ext_cs !== 1'b1 || bus.ext_addr !== 16'h0000) begin
               errors++;
               $display("FAIL cold_cs_edge1: cs=%b addr=%h required 1 0000", bus.ext_cs, bus.ext_addr);
            end
         end
         @(negedge clk);
      end
      checks++;
      if (stalls != 4) begin
         errors++;
         $display("FAIL cold_stall_cycles: got %0d required 4", stalls);
      end
      checks++;
      if (bus.dout !== 16'h1234 || bus.core_cen !== bus.cen) begin
         errors++;
         $display("FAIL cold_data: dout=%h core_cen=%b required 1234 %b", bus.dout, bus.core_cen, bus.cen);
      end
      $display("cold fetch addr=0000 stalls=%0d dout=%h", stalls, bus.dout);
      model_fill(16'h0000);
      @(posedge clk);
      #1;
   endtask

   task automatic test_loop_reuse();
      int req0, st, later;
      req0  = req_cnt;
      later = 0;
      for (int i = 0; i < 5; i++) fetch(16'h0100 + 16'(i), int'($urandom_range(1, 4)), st);
      for (int p = 0; p < 4; p++)
         for (int i = 0; i < 5; i++) begin
            fetch(16'h0100 + 16'(i), 1, st);
            later += st;
         end
      checks++;
      if (req_cnt - req0 != 5) begin
         errors++;
         $display("FAIL loop_requests: got %0d required 5", req_cnt - req0);
      end
      checks++;
      if (later != 0) begin
         errors++;
         $display("FAIL loop_later_stalls: got %0d required 0", later);
      end
   endtask

   task automatic test_conflict();
      int req0, st;
      req0 = req_cnt;
      fetch(16'h0003, 2, st);
      fetch(16'h0013, 1, st);
      fetch(16'h0003, 3, st);
      checks++;
      if (req_cnt - req0 != 3) begin
         errors++;
         $display("FAIL conflict_misses: got %0d required 3", req_cnt - req0);
      end
   endtask

   task automatic test_flush_during_fill();
      int n;
      bus.addr = 16'h0020;
      bus.cen  = 1'b1;
      lat      = 4;
      @(posedge clk);
      #1;
      checks++;
      if (bus.ext_cs !== 1'b1 || bus.ext_addr !== 16'h0020) begin
         errors++;
         $display("FAIL flush_fill_req: cs=%b addr=%h required 1 0020", bus.ext_cs, bus.ext_addr);
      end
      @(posedge clk);
      #1;
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      model_clear();
      n = 0;
      while (bus.ext_cs === 1'b1 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (bus.ext_cs !== 1'b0) begin
         errors++;
         $display("FAIL flush_fill_handshake: cs=%b required 0", bus.ext_cs);
      end
      @(negedge clk);
      checks++;
      if (bus.stall !== 1'b1) begin
         errors++;
         $display("FAIL flush_fill_still_miss: stall=%b required 1", bus.stall);
      end
      lat = 2;
      n = 0;
      while (bus.ext_cs !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.ext_cs !== 1'b1 || bus.ext_addr !== 16'h0020) begin
         errors++;
         $display("FAIL flush_fill_rerequest: cs=%b addr=%h required 1 0020", bus.ext_cs, bus.ext_addr);
      end
      n = 0;
      while (bus.stall === 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.stall !== 1'b0 || bus.dout !== mem_word(16'h0020)) begin
         errors++;
         $display("FAIL flush_fill_refill: stall=%b dout=%h required 0 %h", bus.stall, bus.dout, mem_word(16'h0020));
      end
      $display("flush during fill addr=0020 refill dout=%h", bus.dout);
      model_fill(16'h0020);
      @(posedge clk);
      #1;
   endtask

   task automatic test_cen_gating();
      int req0, st;
      fetch(16'h0005, 1, st);
      req0 = req_cnt;
      for (int i = 0; i < 8; i++) begin
         bus.cen = (i % 2 == 0) ? 1'b1 : 1'b0;
         @(negedge clk);
         checks++;
         if (bus.core_cen !== bus.cen || bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL cen_gating cyc=%0d: core_cen=%b stall=%b required %b 0", i, bus.core_cen, bus.stall, bus.cen);
         end
         $display("cen cyc=%0d cen=%b core_cen=%b", i, bus.cen, bus.core_cen);
         @(posedge clk);
         #1;
      end
      bus.cen = 1'b1;
      checks++;
      if (req_cnt != req0) begin
         errors++;
         $display("FAIL cen_no_requests: got %0d required 0", req_cnt - req0);
      end
   endtask

   task automatic test_flush_idle();
      int req0, n, st;
      fetch(16'h0005, 1, st);
      req0 = req_cnt;
      bus.flush = 1'b1;
      lat = 2;
      @(negedge clk);
      checks++;
      if (bus.stall !== 1'b0) begin
         errors++;
         $display("FAIL flush_idle_same_cycle: stall=%b required 0", bus.stall);
      end
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      model_clear();
      @(negedge clk);
      checks++;
      if (bus.stall !== 1'b1) begin
         errors++;
         $display("FAIL flush_idle_next_miss: stall=%b required 1", bus.stall);
      end
      n = 0;
      while (bus.stall === 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.dout !== mem_word(16'h0005) || req_cnt - req0 != 1) begin
         errors++;
         $display("FAIL flush_idle_refill: dout=%h reqs=%0d required %h 1", bus.dout, req_cnt - req0, mem_word(16'h0005));
      end
      $display("flush idle addr=0005 refill dout=%h", bus.dout);
      model_fill(16'h0005);
      @(posedge clk);
      #1;
   endtask

   task automatic test_async_reset();
      int st;
      bus.addr = 16'h0040;
      bus.cen  = 1'b1;
      lat      = 20;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      #2;
      rstn = 1'b0;
      #1;
      checks++;
      if (bus.ext_cs !== 1'b0 || bus.stall !== 1'b1) begin
         errors++;
         $display("FAIL async_reset_abort: cs=%b stall=%b required 0 1", bus.ext_cs, bus.stall);
      end
      $display("async reset in WAIT: ext_cs=%b", bus.ext_cs);
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      fetch(16'h0020, 2, st);
   endtask

   task automatic test_random();
      int st;
      logic [15:0] a;
      for (int i = 0; i < 40; i++) begin
         a = 16'($urandom_range(0, 63));
         fetch(a, int'($urandom_range(1, 5)), st);
      end
   endtask

   initial begin
      #400000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_loop_reuse();
      test_conflict();
      test_flush_during_fill();
      test_cen_gating();
      test_flush_idle();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
